// File: rtl/mode_ctl_rec_if.sv
// Handshake/bus bundle between the key filters, the mode controller and the musicbox core.
interface mode_ctl_rec_if #(
    parameter int W     = 16,
    parameter int DEPTH = 64
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          mode_chg;
    logic          clr;
    logic [W-1:0]  SW;
    logic [W-1:0]  signal;
    logic [1:0]    model;
    logic          music_box;
    logic          electone;
    logic          writing;
    logic          playback;
    logic [W-1:0]  in;
    logic [LW-1:0] rec_len;
    logic          rec_full;
    logic          play_busy;

    modport master (
        output mode_chg, clr, SW, signal,
        input  model, music_box, electone, writing, playback, in, rec_len, rec_full, play_busy
    );

    modport slave (
        input  mode_chg, clr, SW, signal,
        output model, music_box, electone, writing, playback, in, rec_len, rec_full, play_busy
    );
endinterface

// File: rtl/mode_ctl_rec.sv
// Operating-mode controller with run-length song recorder and looping playback.
// All outputs are registered; the recording lives in a 1R1W synchronous RAM.
module mode_ctl_rec #(
    parameter int W        = 16,
    parameter int DEPTH    = 64,
    parameter int DUR_W    = 8,
    parameter int SLOT_CYC = 5000000,
    parameter int LOOP     = 1
) (
    input  logic           clk,
    input  logic           rst,
    mode_ctl_rec_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [DUR_W-1:0] DMAX = '1;

    typedef enum logic [1:0] {M_BOX = 2'd0, M_ELEC = 2'd1, M_WRITE = 2'd2, M_PLAY = 2'd3} mode_t;
    typedef struct packed {
        logic [W-1:0]     note;
        logic [DUR_W-1:0] dur;
    } entry_t;

    mode_t            mode_q, mode_d;
    logic             music_box, electone, writing, playback;
    logic [CW-1:0]    slot_cnt;
    logic             tick;
    logic [LW-1:0]    rec_len;
    logic             rec_full;
    logic [W-1:0]     cur_note;
    logic [DUR_W-1:0] cur_dur;
    logic             commit;
    entry_t           mem [DEPTH];
    entry_t           rd_data;
    logic [AW-1:0]    ptr;
    logic [1:0]       vld_pipe;
    logic [DUR_W-1:0] rem;
    logic             play_busy;
    logic [W-1:0]     in_q;
    logic             in_write, leave_write, enter_write, enter_play, last_entry;

    assign in_write    = (mode_q == M_WRITE);
    assign enter_write = bus.mode_chg && (mode_q == M_ELEC);
    assign leave_write = bus.mode_chg && in_write;
    assign enter_play  = leave_write;
    assign last_entry  = (LW'(ptr) + LW'(1)) == rec_len;

    always_comb begin
        mode_d = mode_q;
        if (bus.mode_chg) mode_d = mode_t'(mode_q + 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= M_BOX;
            music_box <= 1'b1;
            electone  <= 1'b0;
            writing   <= 1'b0;
            playback  <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            music_box <= (mode_d == M_BOX);
            electone  <= (mode_d == M_ELEC);
            writing   <= (mode_d == M_WRITE);
            playback  <= (mode_d == M_PLAY);
        end
    end

    // Slot timer restarts on every mode change so each mode sees a full first slot.
    assign tick = (slot_cnt == CW'(SLOT_CYC - 1)) && !bus.mode_chg;

    always_ff @(posedge clk) begin
        if (rst || bus.mode_chg || slot_cnt == CW'(SLOT_CYC - 1)) slot_cnt <= '0;
        else                                                       slot_cnt <= slot_cnt + CW'(1);
    end

    always_comb begin
        commit = 1'b0;
        if (in_write && !bus.clr && !rec_full && cur_dur != '0) begin
            if (leave_write) commit = 1'b1;
            else if (tick && !(bus.SW == cur_note && cur_dur != DMAX)) commit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_len  <= '0;
            rec_full <= 1'b0;
            cur_note <= '0;
            cur_dur  <= '0;
        end else if (bus.clr || enter_write) begin
            rec_len  <= '0;
            rec_full <= 1'b0;
            cur_dur  <= '0;
        end else begin
            if (commit) begin
                rec_len  <= rec_len + LW'(1);
                rec_full <= (rec_len == LW'(DEPTH - 1));
            end
            if (leave_write) begin
                cur_dur <= '0;
            end else if (in_write && tick) begin
                if (cur_dur != '0 && bus.SW == cur_note && cur_dur != DMAX) begin
                    cur_dur <= cur_dur + DUR_W'(1);
                end else begin
                    cur_note <= bus.SW;
                    cur_dur  <= DUR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[rec_len[AW-1:0]] <= '{note: cur_note, dur: cur_dur};
    end

    always_ff @(posedge clk) begin
        if (vld_pipe[0]) rd_data <= mem[ptr];
    end

    // vld_pipe[0]: read of mem[ptr] issued; vld_pipe[1]: rd_data holds that entry.
    // Assumes SLOT_CYC >= 3 so an entry reload completes inside one slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q      <= '0;
            ptr       <= '0;
            vld_pipe  <= '0;
            play_busy <= 1'b0;
            rem       <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], 1'b0};
            case (mode_q)
                M_BOX:           in_q <= bus.signal;
                M_ELEC, M_WRITE: in_q <= bus.SW;
                default: ;
            endcase
            if (enter_play) begin
                ptr       <= '0;
                vld_pipe  <= {1'b0, (rec_len != '0) || commit};
                play_busy <= 1'b0;
                in_q      <= '0;
            end else if (mode_q != M_PLAY || bus.clr || bus.mode_chg) begin
                ptr       <= '0;
                vld_pipe  <= '0;
                play_busy <= 1'b0;
                if (mode_q == M_PLAY) in_q <= '0;
            end else if (vld_pipe[1]) begin
                in_q      <= rd_data.note;
                rem       <= rd_data.dur;
                play_busy <= 1'b1;
            end else if (play_busy && tick && !vld_pipe[0]) begin
                if (rem != DUR_W'(1)) begin
                    rem <= rem - DUR_W'(1);
                end else if (!last_entry) begin
                    ptr      <= ptr + AW'(1);
                    vld_pipe <= 2'b01;
                end else if (LOOP != 0) begin
                    ptr      <= '0;
                    vld_pipe <= 2'b01;
                end else begin
                    play_busy <= 1'b0;
                    in_q      <= '0;
                end
            end
        end
    end

    assign bus.model     = mode_q;
    assign bus.music_box = music_box;
    assign bus.electone  = electone;
    assign bus.writing   = writing;
    assign bus.playback  = playback;
    assign bus.in        = in_q;
    assign bus.rec_len   = rec_len;
    assign bus.rec_full  = rec_full;
    assign bus.play_busy = play_busy;
endmodule

// File: doc/mode_ctl_rec.md
Name: mode_ctl_rec

Overview:
- Parametrised successor to the board's operating-mode controller.
- Cycles through four modes on a debounced mode pulse: music box, electone, writing and playback.
- In writing mode it records run-length-encoded switch patterns into an internal buffer. In playback mode it replays them as the note word fed to the music box core.
- Sits between the key filters (no_fitter outputs) and the musicbox core. It replaces the old combinational mode decode with registered, latch-free outputs.

Parameters:
- W, 16, note word width (SW, signal, in).
- DEPTH, 64, number of recorded entries (power of 2, ≥2).
- DUR_W, 8, duration field width; max run length DMAX = 2^DUR_W − 1 slots.
- SLOT_CYC, 5000000, clocks per time slot (50 ms at 100 MHz).
- LOOP, 1, 1 = playback wraps to entry 0 after the last entry; 0 = stop after the last entry.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- mode_chg  in  1  one-cycle pulse, advance mode.
- clr  in  1  one-cycle pulse, erase recording.
- SW  in  W  live switch notes.
- signal  in  W  stored-song notes from the song ROM path.
- model  out  2  current mode: 0 music box, 1 electone, 2 writing, 3 playback.
- music_box, electone, writing, playback  out  1 each  one-hot decode of model.
- in  out  W  registered note word to the musicbox core.
- rec_len  out  clog2(DEPTH)+1  committed entry count.
- rec_full  out  1  rec_len == DEPTH.
- play_busy  out  1  playback actively outputting entries.

Behaviour:
- Reset values, applied at the clk edge with rst=1: model=0, music_box=1, other mode flags 0, in=0, rec_len=0, rec_full=0, play_busy=0, slot counter=0, pending run cleared. Reset discards any recording, including mid-operation.
- Mode advance: mode_chg increments model modulo 4 (3→0). Mode flags are registered decodes of model, so a flag changes in the same cycle as model.
- Slot counter:
  - Counts 0..SLOT_CYC−1 and pulses tick when the count equals SLOT_CYC−1.
  - It is zeroed on every mode_chg, so the first tick in a new mode occurs SLOT_CYC cycles after the change.
  - A tick coinciding with mode_chg is ignored.
- Note output in (1-cycle registered):
  - Mode 0: in = signal.
  - Mode 1: in = SW.
  - Mode 2: in = SW, as a live monitor.
  - Mode 3: in = current playback note, or 0 when idle.
- Entering writing (model 1→2):
  - rec_len and rec_full are cleared; the new recording overwrites the old one.
  - Pending run is set to cur_dur=0.
- Recording, on each tick in writing:
  - If cur_dur==0: cur_note←SW, cur_dur←1.
  - Else if SW==cur_note and cur_dur<DMAX: cur_dur←cur_dur+1.
  - Else: commit {cur_note,cur_dur} to mem[rec_len], rec_len+1, then cur_note←SW, cur_dur←1.
  - SW==0 is recorded as a rest; there is no special case.
  - A run longer than DMAX splits into consecutive entries with the same note.
- Leaving writing (mode_chg in mode 2): a pending run with cur_dur≠0 is committed in that cycle, if not full.
- Full buffer: when rec_len==DEPTH, rec_full=1. Further commits are dropped, and in continues to monitor SW.
- clr:
  - In modes 0, 1 and 3: rec_len←0, rec_full←0, and playback stops with play_busy=0 and in=0.
  - In mode 2: restarts the recording (rec_len←0, cur_dur←0).
  - clr together with mode_chg out of writing: the pending run is discarded.
- Playback, entering mode 3 (2→3):
  - ptr←0. If rec_len==0: play_busy stays 0 and in=0.
  - Otherwise mem[0] is read with a 1-cycle synchronous read. play_busy=1 and in=note from the cycle after the read data returns.
  - The entry is held for dur ticks. When its dur ticks elapse, ptr advances.
  - After entry rec_len−1: if LOOP=1, ptr←0 and playback continues. If LOOP=0, play_busy←0 and in←0 until the mode is exited.
- Leaving playback resets ptr. Re-entering restarts from entry 0.
- Memory: DEPTH×(W+DUR_W), single write port and single synchronous read port. Writes occur only in mode 2 and reads only in mode 3, so no read/write collision is possible.

Test Plan (SLOT_CYC=4, DEPTH=4, DUR_W=3, W=16):
- Reset then mode_chg ×5 → model 0,1,2,3,0,1; exactly one flag high in each mode. In mode 0, signal=16'h00F0 → in=16'h00F0 one cycle later. In mode 1, SW=16'h0003 → in=16'h0003.
- Writing: SW=16'h0001 for 3 ticks, then 16'h0004 for 2 ticks, then mode_chg → rec_len=2, mem={(0001,3),(0004,2)}.
- Playback, LOOP=1: in=0001 for 12 cycles, then 0004 for 8 cycles, then 0001 again; play_busy stays 1.
- Overflow: record 6 distinct notes of 1 tick each → rec_len stops at 4, rec_full=1, last two notes dropped, in still tracks SW.
- Run split: SW constant 16'h0002 for 9 ticks → entries (0002,7) and (0002,2).
- Edge cases:
  - clr in mode 3 mid-note → in=0 and play_busy=0 next cycle.
  - Playback with rec_len=0 → in=0 and play_busy=0 throughout.
  - rst asserted mid-recording → rec_len=0 and model=0.
